// File: rtl/d8m_mipi_power_sequencer.sv
// Power-up/power-down sequencer for the D8M MIPI bridge and sensor.
// Drives timed pwdn_n/reset_n and exposes status and programmable delays over Avalon-MM.
module d8m_mipi_power_sequencer #(
    parameter int T_PWR_DEF  = 50000,
    parameter int T_RST_DEF  = 500000,
    parameter int T_HOLD_DEF = 5000,
    parameter int CNT_W      = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pwdn_req,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        mipi_pwdn_n,
    output logic        mipi_reset_n,
    output logic        mipi_ready
);

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_PWR_WAIT = 3'd1,
        S_RST_WAIT = 3'd2,
        S_READY    = 3'd3,
        S_SHUTDOWN = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] PWR_RST  = CNT_W'(T_PWR_DEF);
    localparam logic [CNT_W-1:0] RST_RST  = CNT_W'(T_RST_DEF);
    localparam logic [CNT_W-1:0] HOLD_RST = CNT_W'(T_HOLD_DEF);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] t_pwr, t_rst, t_hold;
    logic             cnt_load;
    logic [CNT_W-1:0] load_val;
    logic             pwdn_nxt, rst_nxt, rdy_nxt;
    logic             wr_en;
    logic             unused_wdata;

    assign wr_en        = chipselect && !write_n;
    assign unused_wdata = ^writedata[31:CNT_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_pwr  <= PWR_RST;
            t_rst  <= RST_RST;
            t_hold <= HOLD_RST;
        end else if (wr_en) begin
            case (address)
                2'd1:    t_pwr  <= writedata[CNT_W-1:0];
                2'd2:    t_rst  <= writedata[CNT_W-1:0];
                2'd3:    t_hold <= writedata[CNT_W-1:0];
                default: ;
            endcase
        end
    end

    // State, counter and pin registers move together so pins track the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_OFF;
            cnt          <= '0;
            mipi_pwdn_n  <= 1'b0;
            mipi_reset_n <= 1'b0;
            mipi_ready   <= 1'b0;
        end else begin
            state        <= state_nxt;
            mipi_pwdn_n  <= pwdn_nxt;
            mipi_reset_n <= rst_nxt;
            mipi_ready   <= rdy_nxt;
            if (cnt_load)
                cnt <= (load_val == '0) ? '0 : load_val - 1'b1;
            else if (cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

    // A request drop is tested before count end so it wins in the same cycle.
    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        load_val  = '0;
        case (state)
            S_OFF: begin
                if (pwdn_req) begin
                    state_nxt = S_PWR_WAIT;
                    cnt_load  = 1'b1;
                    load_val  = t_pwr;
                end
            end
            S_PWR_WAIT: begin
                if (!pwdn_req) begin
                    state_nxt = S_SHUTDOWN;
                    cnt_load  = 1'b1;
                    load_val  = t_hold;
                end else if (cnt == '0) begin
                    state_nxt = S_RST_WAIT;
                    cnt_load  = 1'b1;
                    load_val  = t_rst;
                end
            end
            S_RST_WAIT: begin
                if (!pwdn_req) begin
                    state_nxt = S_SHUTDOWN;
                    cnt_load  = 1'b1;
                    load_val  = t_hold;
                end else if (cnt == '0) begin
                    state_nxt = S_READY;
                end
            end
            S_READY: begin
                if (!pwdn_req) begin
                    state_nxt = S_SHUTDOWN;
                    cnt_load  = 1'b1;
                    load_val  = t_hold;
                end
            end
            S_SHUTDOWN: begin
                if (cnt == '0)
                    state_nxt = S_OFF;
            end
            default: state_nxt = S_OFF;
        endcase
    end

    always_comb begin
        pwdn_nxt = (state_nxt != S_OFF);
        rst_nxt  = (state_nxt == S_RST_WAIT) || (state_nxt == S_READY);
        rdy_nxt  = (state_nxt == S_READY);
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata = {26'd0, mipi_reset_n, mipi_pwdn_n, state, mipi_ready};
            2'd1: readdata = 32'(t_pwr);
            2'd2: readdata = 32'(t_rst);
            2'd3: readdata = 32'(t_hold);
            default: readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_d8m_mipi_power_sequencer.sv
// Bench for d8m_mipi_power_sequencer: directed table, corner sequences,
// then random request/bus traffic against a phase/remaining-cycles reference.
module tb_d8m_mipi_power_sequencer;

    logic        clk;
    logic        reset_n;
    logic        pwdn_req;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        mipi_pwdn_n;
    logic        mipi_reset_n;
    logic        mipi_ready;

    int n_chk = 0;
    int n_err = 0;

    d8m_mipi_power_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pwdn_req     (pwdn_req),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .mipi_pwdn_n  (mipi_pwdn_n),
        .mipi_reset_n (mipi_reset_n),
        .mipi_ready   (mipi_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        req;
        logic        cs;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        e_pwdn;
        logic        e_rst;
        logic        e_rdy;
        logic        chk_rd;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vt[15];

    // Reference model: phase number plus cycles still to spend in the current phase.
    int          m_phase;
    int          m_left;
    int unsigned m_reg[4];

    function automatic int unsigned at_least_one(input int unsigned v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        logic [2:0] ph;
        logic       p, r, y;
        ph = 3'(m_phase);
        p  = (m_phase != 0);
        r  = (m_phase == 2) || (m_phase == 3);
        y  = (m_phase == 3);
        if (a == 2'd0) return {26'd0, r, p, ph, y};
        return m_reg[a];
    endfunction

    task automatic model_step(input logic req, input logic we, input logic [1:0] a, input logic [31:0] wd);
        case (m_phase)
            0: if (req) begin m_phase = 1; m_left = int'(at_least_one(m_reg[1])); end
            1, 2: begin
                if (!req) begin m_phase = 4; m_left = int'(at_least_one(m_reg[3])); end
                else if (m_left == 1) begin
                    if (m_phase == 1) begin m_phase = 2; m_left = int'(at_least_one(m_reg[2])); end
                    else m_phase = 3;
                end else m_left--;
            end
            3: if (!req) begin m_phase = 4; m_left = int'(at_least_one(m_reg[3])); end
            4: if (m_left == 1) m_phase = 0; else m_left--;
            default: m_phase = 0;
        endcase
        if (we && a != 2'd0) m_reg[a] = wd & 32'h00FF_FFFF;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic req, input logic cs, input logic [1:0] a, input logic [31:0] wd);
        pwdn_req   = req;
        chipselect = cs;
        write_n    = !cs;
        address    = a;
        writedata  = wd;
    endtask

    // One clock: drive inputs, take the edge, drop the strobe, land on the next negedge.
    task automatic cyc(input logic req, input logic cs, input logic [1:0] a, input logic [31:0] wd);
        drive(req, cs, a, wd);
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    logic [31:0] d;
    logic        seen_rdy;

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 32'd0);

        // Table: program T_PWR=4, T_RST=6, then request power at k=2 (cycle 0).
        for (int k = 0; k < 15; k++) begin
            vt[k].req    = (k >= 2);
            vt[k].cs     = (k < 2);
            vt[k].addr   = (k == 0) ? 2'd1 : (k == 1) ? 2'd2 : 2'd0;
            vt[k].wdata  = (k == 0) ? 32'd4 : 32'd6;
            vt[k].e_pwdn = (k >= 3);
            vt[k].e_rst  = (k >= 7);
            vt[k].e_rdy  = (k >= 13);
            vt[k].chk_rd = (k >= 2);
            vt[k].e_rd   = (k < 3) ? 32'h00 : (k < 7) ? 32'h12 : (k < 13) ? 32'h34 : 32'h37;
        end

        @(negedge clk);
        chk("rst_pins", {29'd0, mipi_ready, mipi_reset_n, mipi_pwdn_n}, 32'd0);
        rd(2'd0, d); chk("rst_status", d, 32'd0);
        rd(2'd1, d); chk("rst_t_pwr", d, 32'd50000);
        rd(2'd2, d); chk("rst_t_rst", d, 32'd500000);
        rd(2'd3, d); chk("rst_t_hold", d, 32'd5000);
        @(negedge clk);
        reset_n = 1'b1;

        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            drive(vt[k].req, vt[k].cs, vt[k].addr, vt[k].wdata);
            #1;
            chk($sformatf("tbl%0d_pins", k), {29'd0, mipi_ready, mipi_reset_n, mipi_pwdn_n},
                {29'd0, vt[k].e_rdy, vt[k].e_rst, vt[k].e_pwdn});
            if (vt[k].chk_rd) chk($sformatf("tbl%0d_rd", k), readdata, vt[k].e_rd);
        end

        // Shutdown from READY with T_HOLD=3.
        cyc(1'b1, 1'b1, 2'd3, 32'd3);
        chk("hold_still_ready", {31'd0, mipi_ready}, 32'd1);
        cyc(1'b0, 1'b0, 2'd0, 32'd0);
        chk("hold_sd_status", readdata, 32'h18);
        chk("hold_sd_pins", {29'd0, mipi_ready, mipi_reset_n, mipi_pwdn_n}, 32'b001);
        cyc(1'b0, 1'b0, 2'd0, 32'd0);
        cyc(1'b0, 1'b0, 2'd0, 32'd0);
        chk("hold_pwdn_still_hi", {31'd0, mipi_pwdn_n}, 32'd1);
        cyc(1'b0, 1'b0, 2'd0, 32'd0);
        chk("hold_off_status", readdata, 32'h00);

        // Drop in PWR_WAIT, then request during SHUTDOWN: one OFF cycle before re-power.
        cyc(1'b1, 1'b0, 2'd0, 32'd0);
        chk("rep_pwr_wait", readdata, 32'h12);
        cyc(1'b0, 1'b0, 2'd0, 32'd0);
        chk("rep_sd", readdata, 32'h18);
        cyc(1'b1, 1'b0, 2'd0, 32'd0);
        chk("rep_sd_ignores_req", readdata, 32'h18);
        cyc(1'b1, 1'b0, 2'd0, 32'd0);
        cyc(1'b1, 1'b0, 2'd0, 32'd0);
        chk("rep_off_once", readdata, 32'h00);
        cyc(1'b1, 1'b0, 2'd0, 32'd0);
        chk("rep_pwr_again", readdata, 32'h12);

        // Drop two cycles into RST_WAIT.
        seen_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 2'd0, 32'd0);
            seen_rdy |= mipi_ready;
        end
        chk("rw_pwr_last", readdata, 32'h12);
        cyc(1'b1, 1'b0, 2'd0, 32'd0);
        chk("rw_rst_wait1", readdata, 32'h34);
        cyc(1'b1, 1'b0, 2'd0, 32'd0);
        chk("rw_rst_wait2", readdata, 32'h34);
        cyc(1'b0, 1'b0, 2'd0, 32'd0);
        chk("rw_drop_sd", readdata, 32'h18);
        for (int i = 0; i < 3; i++) begin
            seen_rdy |= mipi_ready;
            cyc(1'b0, 1'b0, 2'd0, 32'd0);
        end
        chk("rw_never_ready", {31'd0, seen_rdy}, 32'd0);
        chk("rw_off", readdata, 32'h00);

        // Zero delay and truncation of wide writes.
        cyc(1'b0, 1'b1, 2'd1, 32'd0);
        cyc(1'b0, 1'b1, 2'd2, 32'h1234_5678);
        rd(2'd1, d); chk("z_t_pwr", d, 32'd0);
        rd(2'd2, d); chk("z_t_rst", d, 32'h0034_5678);
        cyc(1'b1, 1'b0, 2'd0, 32'd0);
        chk("z_pwr_wait", readdata, 32'h12);
        cyc(1'b1, 1'b0, 2'd0, 32'd0);
        chk("z_rst_wait", readdata, 32'h34);
        cyc(1'b1, 1'b0, 2'd0, 32'd0);

        // Asynchronous reset in the middle of RST_WAIT.
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_pins", {29'd0, mipi_ready, mipi_reset_n, mipi_pwdn_n}, 32'd0);
        rd(2'd0, d); chk("ar_status", d, 32'd0);
        rd(2'd1, d); chk("ar_t_pwr", d, 32'd50000);
        rd(2'd2, d); chk("ar_t_rst", d, 32'd500000);
        rd(2'd3, d); chk("ar_t_hold", d, 32'd5000);
        @(negedge clk);
        reset_n = 1'b1;

        // Random traffic against the reference model.
        m_phase  = 0;
        m_left   = 0;
        m_reg[0] = 0;
        m_reg[1] = 50000;
        m_reg[2] = 500000;
        m_reg[3] = 5000;
        pwdn_req = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic        r, cs;
            logic [1:0]  a;
            logic [31:0] wd;
            @(negedge clk);
            r  = ($urandom_range(0, 9) == 0) ? !pwdn_req : pwdn_req;
            cs = ($urandom_range(0, 5) == 0);
            a  = 2'($urandom_range(0, 3));
            wd = ($urandom & 32'hFF00_0000) | 32'($urandom_range(0, 9));
            drive(r, cs, a, wd);
            #1;
            chk("rnd_pins", {29'd0, mipi_ready, mipi_reset_n, mipi_pwdn_n},
                {29'd0, m_phase == 3, m_phase == 2 || m_phase == 3, m_phase != 0});
            chk("rnd_rd", readdata, model_read(a));
            @(posedge clk);
            model_step(r, cs, a, wd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
